// File: rtl/sspi_pkg.sv
// Shared definitions for the SPI slave: command codes, header field positions, error bit indices.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sspi_pkg;

  typedef enum logic [3:0] {
    CMD_REG_READ    = 4'd0,
    CMD_REG_WRITE   = 4'd1,
    CMD_BUF_READ    = 4'd2,
    CMD_BUF_WRITE   = 4'd3,
    CMD_STATUS_READ = 4'd4
  } cmd_e;

  // Header word layout: {cmd[3:0], ch[3:0], blen[7:0], addr[15:0]}
  localparam int HDR_CMD_LSB  = 28;
  localparam int HDR_CH_LSB   = 24;
  localparam int HDR_BLEN_LSB = 16;
  localparam int HDR_ADDR_LSB = 0;

  // err_flags = {err_cmd, err_ch, err_ovr}
  localparam int ERR_OVR = 0;
  localparam int ERR_CH  = 1;
  localparam int ERR_CMD = 2;

  function automatic logic cmd_known(input logic [3:0] c);
    return (c <= 4'd4);
  endfunction

endpackage

// File: rtl/sspi_intf_mc_if.sv
// Bundle of SPI pins, CSR bus, RX/TX buffer ports and status for the multi-channel SPI slave.
// Latency: n/a (wiring only).
// Backpressure: none; tx_buf_rdata/csr_rdata are expected one cycle after the read strobe.
interface sspi_intf_mc_if #(
  parameter int NUM_CH   = 4,
  parameter int BUF_SIZE = 256
);
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BUF_ADWIDTH = (BUF_SIZE > 1) ? $clog2(BUF_SIZE) : 1;

  logic                   ss_n;
  logic                   mosi;
  logic                   miso;
  logic                   csr_sel;
  logic                   csr_we;
  logic                   csr_re;
  logic [15:0]            csr_addr;
  logic [31:0]            csr_wdata;
  logic [31:0]            csr_rdata;
  logic [CH_W-1:0]        rx_buf_ch;
  logic                   rx_buf_we;
  logic [BUF_ADWIDTH-1:0] rx_buf_waddr;
  logic [31:0]            rx_buf_wdata;
  logic [CH_W-1:0]        tx_buf_ch;
  logic                   tx_buf_re;
  logic [BUF_ADWIDTH-1:0] tx_buf_raddr;
  logic [31:0]            tx_buf_rdata;
  logic [2:0]             err_flags;
  logic                   xfer_done;

  modport slave (
    input  ss_n, mosi, csr_rdata, tx_buf_rdata,
    output miso, csr_sel, csr_we, csr_re, csr_addr, csr_wdata,
           rx_buf_ch, rx_buf_we, rx_buf_waddr, rx_buf_wdata,
           tx_buf_ch, tx_buf_re, tx_buf_raddr, err_flags, xfer_done
  );

  modport master (
    output ss_n, mosi, csr_rdata, tx_buf_rdata,
    input  miso, csr_sel, csr_we, csr_re, csr_addr, csr_wdata,
           rx_buf_ch, rx_buf_we, rx_buf_waddr, rx_buf_wdata,
           tx_buf_ch, tx_buf_re, tx_buf_raddr, err_flags, xfer_done
  );

endinterface

// File: rtl/sspi_mc_hdr.sv
// Header capture and decode: latches cmd/ch/blen/addr from word 0 and flags bad cmd / bad channel.
// Latency: fields registered at the bit-31 edge of word 0; error/status hints are combinational on that edge.
// Backpressure: none; cleared whenever the transfer is not active.
module sspi_mc_hdr
  import sspi_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic        sclk,
  input  logic        rst_n_sclk,
  input  logic        latch,
  input  logic        clr,
  input  logic [31:0] word,
  output cmd_e        cmd,
  output logic        hdr_vld,
  output logic        ch_ok,
  output logic [3:0]  ch,
  output logic [7:0]  blen,
  output logic [15:0] addr,
  output logic        set_err_cmd,
  output logic        set_err_ch,
  output logic        status_now,
  output logic        reg_now
);

  logic [3:0] w_cmd;
  logic [3:0] w_ch;
  logic       w_known;
  logic       w_buf;
  logic       w_ch_ok;

  assign w_cmd   = word[HDR_CMD_LSB +: 4];
  assign w_ch    = word[HDR_CH_LSB +: 4];
  assign w_known = cmd_known(w_cmd);
  assign w_buf   = (w_cmd == CMD_BUF_READ) || (w_cmd == CMD_BUF_WRITE);
  assign w_ch_ok = ({28'd0, w_ch} < 32'(NUM_CH));

  assign set_err_cmd = latch && !w_known;
  assign set_err_ch  = latch && w_buf && !w_ch_ok;
  assign status_now  = latch && (w_cmd == CMD_STATUS_READ);
  assign reg_now     = latch && ((w_cmd == CMD_REG_READ) || (w_cmd == CMD_REG_WRITE));

  // Hold the decoded header for the rest of the transfer; an unknown cmd leaves hdr_vld low so nothing acts on it.
  always_ff @(posedge sclk or negedge rst_n_sclk) begin
    if (!rst_n_sclk) begin
      cmd     <= CMD_REG_READ;
      hdr_vld <= 1'b0;
      ch_ok   <= 1'b0;
      ch      <= 4'd0;
      blen    <= 8'd0;
      addr    <= 16'd0;
    end else if (clr) begin
      cmd     <= CMD_REG_READ;
      hdr_vld <= 1'b0;
      ch_ok   <= 1'b0;
      ch      <= 4'd0;
      blen    <= 8'd0;
      addr    <= 16'd0;
    end else if (latch) begin
      cmd     <= w_known ? cmd_e'(w_cmd) : CMD_REG_READ;
      hdr_vld <= w_known;
      ch_ok   <= w_ch_ok;
      ch      <= w_ch;
      blen    <= word[HDR_BLEN_LSB +: 8];
      addr    <= word[HDR_ADDR_LSB +: 16];
    end
  end

endmodule

// File: rtl/sspi_intf_mc.sv
// SPI slave bridging 32-bit words to a CSR bus and per-channel RX/TX buffers, with sticky error flags.
// Latency: write strobe one cycle after bit 31 of a data word; read strobe one cycle after its first bit; read data returns one word later.
// Backpressure: none; the SPI master owns the pace, excess write words are dropped and flagged.
module sspi_intf_mc
  import sspi_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int BUF_SIZE = 256
) (
  input logic           sclk,
  input logic           rst_n_sclk,
  sspi_intf_mc_if.slave bus
);

  localparam int BUF_ADWIDTH = (BUF_SIZE > 1) ? $clog2(BUF_SIZE) : 1;
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                   armed, in_xfer, active, ss_rise;
  logic [4:0]             bit_count;
  logic [8:0]             word_count, k_off;
  logic [30:0]            rx_data;
  logic [31:0]            word, tx_data, tx_load, rd_hold;
  logic                   word_end, hdr_latch, data_k, k_in_len;
  cmd_e                   cmd;
  logic                   hdr_vld, ch_ok;
  logic [3:0]             ch;
  logic [7:0]             blen;
  logic [15:0]            addr;
  logic                   set_err_cmd, set_err_ch, status_now, reg_now;
  logic                   is_reg, is_wr, is_rd, strobe_ok, ovr_set, err_clr, rd_pend;
  logic [2:0]             err_set, err_flags;
  logic                   miso, csr_sel, csr_we, csr_re, rx_buf_we, tx_buf_re, xfer_done;
  logic [15:0]            csr_addr;
  logic [31:0]            csr_wdata, rx_buf_wdata;
  logic [CH_W-1:0]        rx_buf_ch, tx_buf_ch;
  logic [BUF_ADWIDTH-1:0] rx_buf_waddr, tx_buf_raddr;

  assign active    = ~bus.ss_n & armed;
  assign ss_rise   = bus.ss_n & in_xfer;
  assign word      = {rx_data, bus.mosi};
  assign word_end  = active && (bit_count == 5'd31);
  assign hdr_latch = word_end && (word_count == 9'd0);
  assign data_k    = (word_count != 9'd0);
  assign k_in_len  = data_k && (word_count <= {1'b0, blen});
  assign k_off     = word_count - 9'd1;
  assign is_reg    = hdr_vld && ((cmd == CMD_REG_READ) || (cmd == CMD_REG_WRITE));
  assign is_wr     = hdr_vld && ((cmd == CMD_REG_WRITE) || (cmd == CMD_BUF_WRITE));
  assign is_rd     = hdr_vld && ((cmd == CMD_REG_READ) || (cmd == CMD_BUF_READ));
  assign strobe_ok = is_reg || ch_ok;
  assign ovr_set   = word_end && data_k && is_wr && !k_in_len;
  assign err_clr   = ss_rise && hdr_vld && (cmd == CMD_STATUS_READ);

  sspi_mc_hdr #(.NUM_CH(NUM_CH)) u_hdr (
    .sclk        (sclk),
    .rst_n_sclk  (rst_n_sclk),
    .latch       (hdr_latch),
    .clr         (~active),
    .word        (word),
    .cmd         (cmd),
    .hdr_vld     (hdr_vld),
    .ch_ok       (ch_ok),
    .ch          (ch),
    .blen        (blen),
    .addr        (addr),
    .set_err_cmd (set_err_cmd),
    .set_err_ch  (set_err_ch),
    .status_now  (status_now),
    .reg_now     (reg_now)
  );

  // Gather this cycle's error events into flag positions.
  always_comb begin
    err_set          = 3'b000;
    err_set[ERR_CMD] = set_err_cmd;
    err_set[ERR_CH]  = set_err_ch;
    err_set[ERR_OVR] = ovr_set;
  end

  // Word loaded into the TX shifter at each word boundary: status or 0 after the header, held read data after in-range read words.
  always_comb begin
    tx_load = 32'd0;
    if (hdr_latch) begin
      if (status_now) tx_load = {29'd0, err_flags};
    end else if (is_rd && k_in_len && strobe_ok) begin
      tx_load = rd_hold;
    end
  end

  // Session tracking: a transfer only starts after ss_n has been seen high since reset.
  always_ff @(posedge sclk or negedge rst_n_sclk) begin
    if (!rst_n_sclk) begin
      armed     <= 1'b0;
      in_xfer   <= 1'b0;
      xfer_done <= 1'b0;
    end else begin
      armed     <= armed | bus.ss_n;
      in_xfer   <= active;
      xfer_done <= ss_rise;
    end
  end

  // RX shift and bit/word counters; everything restarts when the transfer is not active, dropping partial words.
  always_ff @(posedge sclk or negedge rst_n_sclk) begin
    if (!rst_n_sclk) begin
      rx_data    <= '0;
      bit_count  <= 5'd0;
      word_count <= 9'd0;
    end else if (!active) begin
      rx_data    <= '0;
      bit_count  <= 5'd0;
      word_count <= 9'd0;
    end else begin
      rx_data   <= word[30:0];
      bit_count <= bit_count + 5'd1;
      if (bit_count == 5'd31 && word_count != 9'd511) word_count <= word_count + 9'd1;
    end
  end

  // TX shifter: parallel load at each word boundary, otherwise shift left.
  always_ff @(posedge sclk or negedge rst_n_sclk) begin
    if (!rst_n_sclk)              tx_data <= 32'd0;
    else if (!active)             tx_data <= 32'd0;
    else if (bit_count == 5'd31)  tx_data <= tx_load;
    else                          tx_data <= {tx_data[30:0], 1'b0};
  end

  // miso changes on the falling edge so the master sees a stable bit at the next rising edge.
  always_ff @(negedge sclk or negedge rst_n_sclk) begin
    if (!rst_n_sclk) miso <= 1'b0;
    else             miso <= tx_data[31];
  end

  // CSR and buffer strobes: single-cycle pulses with address offset k-1 from the header.
  always_ff @(posedge sclk or negedge rst_n_sclk) begin
    if (!rst_n_sclk) begin
      csr_we       <= 1'b0;
      csr_re       <= 1'b0;
      csr_addr     <= 16'd0;
      csr_wdata    <= 32'd0;
      rx_buf_we    <= 1'b0;
      rx_buf_ch    <= '0;
      rx_buf_waddr <= '0;
      rx_buf_wdata <= 32'd0;
      tx_buf_re    <= 1'b0;
      tx_buf_ch    <= '0;
      tx_buf_raddr <= '0;
    end else begin
      csr_we    <= 1'b0;
      csr_re    <= 1'b0;
      rx_buf_we <= 1'b0;
      tx_buf_re <= 1'b0;
      if (word_end && is_wr && k_in_len && strobe_ok) begin
        if (is_reg) begin
          csr_we    <= 1'b1;
          csr_addr  <= addr + 16'(k_off);
          csr_wdata <= word;
        end else begin
          rx_buf_we    <= 1'b1;
          rx_buf_ch    <= CH_W'(ch);
          rx_buf_waddr <= BUF_ADWIDTH'(k_off);
          rx_buf_wdata <= word;
        end
      end
      if (active && bit_count == 5'd0 && is_rd && k_in_len && strobe_ok) begin
        if (is_reg) begin
          csr_re   <= 1'b1;
          csr_addr <= addr + 16'(k_off);
        end else begin
          tx_buf_re    <= 1'b1;
          tx_buf_ch    <= CH_W'(ch);
          tx_buf_raddr <= BUF_ADWIDTH'(k_off);
        end
      end
    end
  end

  // Capture read data one cycle after the source sees the strobe (source has one cycle of latency).
  always_ff @(posedge sclk or negedge rst_n_sclk) begin
    if (!rst_n_sclk) begin
      rd_pend <= 1'b0;
      rd_hold <= 32'd0;
    end else begin
      rd_pend <= csr_re | tx_buf_re;
      if (rd_pend) rd_hold <= is_reg ? bus.csr_rdata : bus.tx_buf_rdata;
    end
  end

  // csr_sel covers register transfers from header latch until ss_n deasserts.
  always_ff @(posedge sclk or negedge rst_n_sclk) begin
    if (!rst_n_sclk)    csr_sel <= 1'b0;
    else if (!active)   csr_sel <= 1'b0;
    else if (hdr_latch) csr_sel <= reg_now;
  end

  // Sticky error flags; a new error in the clearing cycle still lands.
  always_ff @(posedge sclk or negedge rst_n_sclk) begin
    if (!rst_n_sclk) err_flags <= 3'b000;
    else             err_flags <= (err_clr ? 3'b000 : err_flags) | err_set;
  end

  assign bus.miso         = miso;
  assign bus.csr_sel      = csr_sel;
  assign bus.csr_we       = csr_we;
  assign bus.csr_re       = csr_re;
  assign bus.csr_addr     = csr_addr;
  assign bus.csr_wdata    = csr_wdata;
  assign bus.rx_buf_ch    = rx_buf_ch;
  assign bus.rx_buf_we    = rx_buf_we;
  assign bus.rx_buf_waddr = rx_buf_waddr;
  assign bus.rx_buf_wdata = rx_buf_wdata;
  assign bus.tx_buf_ch    = tx_buf_ch;
  assign bus.tx_buf_re    = tx_buf_re;
  assign bus.tx_buf_raddr = tx_buf_raddr;
  assign bus.err_flags    = err_flags;
  assign bus.xfer_done    = xfer_done;

endmodule

// File: doc/sspi_intf_mc.md
SSPI_INTF_MC -- requirements
Module: sspi_intf_mc

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning the number of buffer channels (1..16).
REQ-002 SHALL have parameter BUF_SIZE, default 256, meaning words per channel buffer; BUF_ADWIDTH = clog2(BUF_SIZE).
REQ-003 SHALL have port sclk, input, 1, SPI clock, free-running.
REQ-004 SHALL have port rst_n_sclk, input, 1, reset: asynchronous, active-low.
REQ-005 SHALL have ports ss_n input 1 (slave select, active-low), mosi input 1, and miso output 1.
REQ-006 SHALL have ports csr_sel, csr_we, and csr_re, each output 1; csr_addr output 16; csr_wdata output 32; csr_rdata input 32.
REQ-007 SHALL have ports rx_buf_ch output clog2(NUM_CH), rx_buf_we output 1, rx_buf_waddr output BUF_ADWIDTH, and rx_buf_wdata output 32.
REQ-008 SHALL have ports tx_buf_ch output clog2(NUM_CH), tx_buf_re output 1, tx_buf_raddr output BUF_ADWIDTH, and tx_buf_rdata input 32 (valid one cycle after tx_buf_re).
REQ-009 SHALL have ports err_flags output 3 ({err_cmd, err_ch, err_ovr}, sticky) and xfer_done output 1 (pulse).

Function
REQ-010 SHALL shift mosi MSB-first into rx_data on posedge sclk while ss_n=0; bit_count 0..31; word_count saturates at 511.
REQ-011 SHALL latch the header at the edge sampling bit 31 of word 0, with fields cmd=[31:28], ch=[27:24], blen=[23:16] (N data words), and addr=[15:0].
REQ-012 SHALL decode cmd as 0 REG_READ, 1 REG_WRITE, 2 BUF_READ, 3 BUF_WRITE, 4 STATUS_READ; any other value sets err_cmd and the transaction is ignored.
REQ-013 SHALL, for a buffer command with ch>=NUM_CH, set err_ch and suppress all buffer strobes for that transaction.
REQ-014 Write (REG_WRITE/BUF_WRITE): for data word k (1..N), SHALL pulse csr_we or rx_buf_we for one cycle, in the cycle after bit 31 is sampled, with wdata = word k.
REQ-015 For REQ-014, the write address SHALL be csr_addr = addr+k-1 (16-bit wrap) or rx_buf_waddr = (k-1) mod BUF_SIZE, with rx_buf_ch = ch.
REQ-016 SHALL, for write words k>N, issue no strobe and set err_ovr.
REQ-017 Read (REG_READ/BUF_READ): for k=1..N, SHALL pulse csr_re or tx_buf_re for one cycle, in the cycle after bit 0 of word k is sampled.
REQ-018 For REQ-017, the read address SHALL be csr_addr = addr+k-1 or tx_buf_raddr = (k-1) mod BUF_SIZE, with tx_buf_ch = ch; returned data SHALL be held in a 32-bit register.
REQ-019 The held read word SHALL load into tx_data at bit 31 of word k and be transmitted as word k+1; word 1 SHALL be 0x0000_0000; words beyond N+1 SHALL be 0.
REQ-020 SHALL, for STATUS_READ, return {29'b0, err_flags} as word 1; err_flags SHALL clear on the ss_n rising edge ending that transaction.
REQ-021 SHALL shift tx_data left on posedge sclk and drive miso from tx_data[31] on negedge sclk; tx_data SHALL be 0 while ss_n=1.
REQ-022 csr_sel SHALL be 1 from header latch until ss_n=1 for REG_READ/REG_WRITE only.
REQ-023 On ss_n rising, SHALL clear counters and cmd, discard any partial word with no strobe, and pulse xfer_done for one cycle.
REQ-024 SHALL give err_flags precedence to set over clear when both occur in the same cycle.

Reset
REQ-025 On rst_n_sclk=0, all outputs SHALL reset to 0: miso, strobes, addresses, channels, err_flags, xfer_done, and internal header and shift registers.
REQ-026 Reset mid-transaction SHALL abort it; after release, a new transaction SHALL require ss_n high-then-low.

Structure
REQ-027 Package sspi_pkg SHALL hold the cmd enum, header field positions, and err_flags bit indices.
REQ-028 Header capture and decode, including error checks, SHALL be sub-module sspi_mc_hdr; shifting, counters, and strobes SHALL remain in the top module.

Verification
REQ-029 BUF_WRITE ch=2, N=3, data A,B,C: rx_buf_we pulses at waddr 0,1,2, rx_buf_ch=2, err_flags=0.
REQ-030 BUF_READ ch=1, N=2, buffer[0]=0x1111_1111, buffer[1]=0x2222_2222: miso words 1..3 are 0x0, 0x1111_1111, 0x2222_2222.
REQ-031 REG_WRITE addr=0xFFFF, N=2: csr_we at csr_addr 0xFFFF then 0x0000.
REQ-032 BUF_WRITE ch=7 with NUM_CH=4, plus a BUF_WRITE with N=1 sending 2 data words: no rx_buf_we for ch=7, err_ch=1, err_ovr=1.
REQ-033 STATUS_READ after REQ-032: word 1 is 0x0000_0003, and err_flags=0 after ss_n rises.
REQ-034 ss_n raised at bit 17 of data word 1 of a BUF_WRITE: no rx_buf_we, and xfer_done pulses once.
